// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//
// Shares one single-port unified memory between instruction fetch (I port,
// read-only) and the load/store stage (D port, read/write). Only one access is
// in flight at a time. A grant is issued combinationally in the IDLE cycle a
// request is seen. The response comes back a fixed MEM_LAT cycles later. A
// streak counter makes sure a busy D port cannot starve fetch forever.
//
// Ports:
//   clk_i        clock, rising edge
//   rst_ni       asynchronous active-low reset
//   i_req_i      fetch request, held with i_addr_i until i_gnt_o
//   i_addr_i     fetch byte address
//   i_gnt_o      fetch request accepted this cycle
//   i_rvalid_o   i_rdata_o valid this cycle
//   i_rdata_o    fetch data (0 unless i_rvalid_o)
//   d_req_i      data request, held with d_we/d_addr/d_wdata/d_wstrb until d_gnt_o
//   d_we_i       1 = store, 0 = load
//   d_addr_i     data byte address
//   d_wdata_i    store data
//   d_wstrb_i    store byte strobes
//   d_gnt_o      data request accepted this cycle
//   d_rvalid_o   load data valid / store complete
//   d_rdata_o    load data (0 for stores and whenever d_rvalid_o is 0)
//   mem_en_o     memory access strobe
//   mem_we_o     memory write enable
//   mem_addr_o   memory byte address
//   mem_wdata_o  memory write data
//   mem_wstrb_o  memory byte strobes
//   mem_rdata_i  memory read data, valid MEM_LAT cycles after mem_en_o
//   busy_o       a transaction is in flight
// -----------------------------------------------------------------------------
module mem_arbiter #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned MEM_LAT    = 1,
  parameter int unsigned MAX_STREAK = 4
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    i_req_i,
  input  logic [ADDR_WIDTH-1:0]   i_addr_i,
  output logic                    i_gnt_o,
  output logic                    i_rvalid_o,
  output logic [DATA_WIDTH-1:0]   i_rdata_o,
  input  logic                    d_req_i,
  input  logic                    d_we_i,
  input  logic [ADDR_WIDTH-1:0]   d_addr_i,
  input  logic [DATA_WIDTH-1:0]   d_wdata_i,
  input  logic [DATA_WIDTH/8-1:0] d_wstrb_i,
  output logic                    d_gnt_o,
  output logic                    d_rvalid_o,
  output logic [DATA_WIDTH-1:0]   d_rdata_o,
  output logic                    mem_en_o,
  output logic                    mem_we_o,
  output logic [ADDR_WIDTH-1:0]   mem_addr_o,
  output logic [DATA_WIDTH-1:0]   mem_wdata_o,
  output logic [DATA_WIDTH/8-1:0] mem_wstrb_o,
  input  logic [DATA_WIDTH-1:0]   mem_rdata_i,
  output logic                    busy_o
);

  // A latency of 0 is not meaningful for a registered macro; treat it as 1.
  localparam int unsigned LAT   = (MEM_LAT < 1) ? 1 : MEM_LAT;
  localparam int unsigned CNT_W = (LAT < 2) ? 1 : $clog2(LAT + 1);
  localparam int unsigned STK_W = (MAX_STREAK < 2) ? 1 : $clog2(MAX_STREAK + 1);
  localparam int unsigned SW    = DATA_WIDTH / 8;

  localparam logic [CNT_W-1:0] LAT_C = CNT_W'(LAT);
  localparam logic [CNT_W-1:0] ONE_C = CNT_W'(1);
  localparam logic [STK_W-1:0] MAX_C = STK_W'(MAX_STREAK);
  localparam logic [STK_W-1:0] SONE_C = STK_W'(1);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_e;

  state_e           state_q, state_d;
  owner_e           owner_q, owner_d;
  logic             store_q, store_d;
  logic [CNT_W-1:0] lat_cnt_q, lat_cnt_d;
  logic [STK_W-1:0] streak_q, streak_d;

  logic             d_wins_s;
  logic             req_any_s;

  // D normally wins a contested cycle; once it has won MAX_STREAK contested
  // grants in a row, fetch is forced through.
  assign d_wins_s  = d_req_i & ~(i_req_i & (streak_q == MAX_C));
  // Gating with rst_ni keeps every strobe low while reset is held, even if
  // requesters keep their requests up.
  assign req_any_s = rst_ni & (i_req_i | d_req_i);

  // State register, owner/type latch, latency and streak counters.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= ST_IDLE;
      owner_q   <= OWN_I;
      store_q   <= 1'b0;
      lat_cnt_q <= {CNT_W{1'b0}};
      streak_q  <= {STK_W{1'b0}};
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      store_q   <= store_d;
      lat_cnt_q <= lat_cnt_d;
      streak_q  <= streak_d;
    end
  end

  // Arbitration, next-state logic and all outputs.
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    store_d     = store_q;
    lat_cnt_d   = lat_cnt_q;
    streak_d    = streak_q;
    i_gnt_o     = 1'b0;
    i_rvalid_o  = 1'b0;
    i_rdata_o   = {DATA_WIDTH{1'b0}};
    d_gnt_o     = 1'b0;
    d_rvalid_o  = 1'b0;
    d_rdata_o   = {DATA_WIDTH{1'b0}};
    mem_en_o    = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = {ADDR_WIDTH{1'b0}};
    mem_wdata_o = {DATA_WIDTH{1'b0}};
    mem_wstrb_o = {SW{1'b0}};
    busy_o      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (req_any_s) begin
          mem_en_o  = 1'b1;
          state_d   = ST_BUSY;
          lat_cnt_d = ONE_C;
          if (d_wins_s) begin
            d_gnt_o     = 1'b1;
            mem_we_o    = d_we_i;
            mem_addr_o  = d_addr_i;
            mem_wdata_o = d_wdata_i;
            mem_wstrb_o = d_wstrb_i;
            owner_d     = OWN_D;
            store_d     = d_we_i;
            // Only a grant that actually made fetch wait counts toward the streak.
            if (i_req_i) begin
              if (streak_q == MAX_C) begin
                streak_d = streak_q;
              end else begin
                streak_d = streak_q + SONE_C;
              end
            end else begin
              streak_d = {STK_W{1'b0}};
            end
          end else begin
            i_gnt_o    = 1'b1;
            mem_addr_o = i_addr_i;
            owner_d    = OWN_I;
            store_d    = 1'b0;
            streak_d   = {STK_W{1'b0}};
          end
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_BUSY: begin
        busy_o = 1'b1;
        if (lat_cnt_q == LAT_C) begin
          // Response cycle: mem_rdata is steered to the owner only.
          state_d   = ST_IDLE;
          lat_cnt_d = {CNT_W{1'b0}};
          if (owner_q == OWN_D) begin
            d_rvalid_o = 1'b1;
            if (store_q) begin
              d_rdata_o = {DATA_WIDTH{1'b0}};
            end else begin
              d_rdata_o = mem_rdata_i;
            end
          end else begin
            i_rvalid_o = 1'b1;
            i_rdata_o  = mem_rdata_i;
          end
        end else begin
          lat_cnt_d = lat_cnt_q + ONE_C;
        end
      end

      default: begin
        state_d   = ST_IDLE;
        lat_cnt_d = {CNT_W{1'b0}};
      end
    endcase
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
//
// Two arbiters (MEM_LAT=1 and MEM_LAT=3) are driven side by side. A
// transaction-level model predicts every output on every cycle. It uses the
// time each access finishes, a reference memory image and a streak count. A
// memory stand-in answers mem_* with the configured latency and returns junk
// on all other cycles. After each directed phase, literal expectations are
// checked against a log of the grants and responses the DUTs actually produced.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;

  localparam int MAX_STREAK = 4;
  localparam int LAT0       = 1;
  localparam int LAT1       = 3;

  logic        clk = 1'b0;
  logic        rst_n     [2];
  logic        i_req     [2];
  logic [31:0] i_addr    [2];
  logic        i_gnt     [2];
  logic        i_rvalid  [2];
  logic [31:0] i_rdata   [2];
  logic        d_req     [2];
  logic        d_we      [2];
  logic [31:0] d_addr    [2];
  logic [31:0] d_wdata   [2];
  logic [3:0]  d_wstrb   [2];
  logic        d_gnt     [2];
  logic        d_rvalid  [2];
  logic [31:0] d_rdata   [2];
  logic        mem_en    [2];
  logic        mem_we    [2];
  logic [31:0] mem_addr  [2];
  logic [31:0] mem_wdata [2];
  logic [3:0]  mem_wstrb [2];
  logic [31:0] mem_rdata [2];
  logic        busy      [2];

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_LAT(LAT0), .MAX_STREAK(MAX_STREAK)) u_lat1 (
    .clk_i(clk), .rst_ni(rst_n[0]),
    .i_req_i(i_req[0]), .i_addr_i(i_addr[0]), .i_gnt_o(i_gnt[0]),
    .i_rvalid_o(i_rvalid[0]), .i_rdata_o(i_rdata[0]),
    .d_req_i(d_req[0]), .d_we_i(d_we[0]), .d_addr_i(d_addr[0]),
    .d_wdata_i(d_wdata[0]), .d_wstrb_i(d_wstrb[0]), .d_gnt_o(d_gnt[0]),
    .d_rvalid_o(d_rvalid[0]), .d_rdata_o(d_rdata[0]),
    .mem_en_o(mem_en[0]), .mem_we_o(mem_we[0]), .mem_addr_o(mem_addr[0]),
    .mem_wdata_o(mem_wdata[0]), .mem_wstrb_o(mem_wstrb[0]),
    .mem_rdata_i(mem_rdata[0]), .busy_o(busy[0])
  );

  mem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_LAT(LAT1), .MAX_STREAK(MAX_STREAK)) u_lat3 (
    .clk_i(clk), .rst_ni(rst_n[1]),
    .i_req_i(i_req[1]), .i_addr_i(i_addr[1]), .i_gnt_o(i_gnt[1]),
    .i_rvalid_o(i_rvalid[1]), .i_rdata_o(i_rdata[1]),
    .d_req_i(d_req[1]), .d_we_i(d_we[1]), .d_addr_i(d_addr[1]),
    .d_wdata_i(d_wdata[1]), .d_wstrb_i(d_wstrb[1]), .d_gnt_o(d_gnt[1]),
    .d_rvalid_o(d_rvalid[1]), .d_rdata_o(d_rdata[1]),
    .mem_en_o(mem_en[1]), .mem_we_o(mem_we[1]), .mem_addr_o(mem_addr[1]),
    .mem_wdata_o(mem_wdata[1]), .mem_wstrb_o(mem_wstrb[1]),
    .mem_rdata_i(mem_rdata[1]), .busy_o(busy[1])
  );

  int n_pass = 0;
  int n_tot  = 0;
  int cyc    = 0;
  int cur_pc = 0;

  logic        i_pend [2];
  logic        d_pend [2];
  int          rst_cnt [2];

  logic [31:0] refmem [2][128];
  logic [31:0] envmem [2][128];
  int          env_due  [2];
  logic [31:0] env_data [2];

  // Model state: cycle at which the port becomes free, pending response.
  int          m_free    [2];
  int          m_rv_cyc  [2];
  int          m_streak  [2];
  logic        m_rv_d    [2];
  logic [31:0] m_rv_data [2];

  // Logs of what the DUTs actually did during the current phase.
  int          g_n  [2];
  int          g_pc [2][64];
  logic        g_d  [2][64];
  logic        g_we [2][64];
  logic [3:0]  g_st [2][64];
  int          rv_n    [2];
  int          rv_pc   [2][64];
  logic        rv_d    [2][64];
  logic [31:0] rv_data [2][64];

  function automatic int lat_of(input int k);
    return (k == 0) ? LAT0 : LAT1;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                        input logic [3:0] strb);
    logic [31:0] r;
    r = old_w;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) r[8*b +: 8] = new_w[8*b +: 8];
    end
    return r;
  endfunction

  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    a = {23'd0, 7'($urandom_range(0, 127)), 2'b00};
    if ($urandom_range(0, 7) == 0) a[1:0] = 2'($urandom);
    return a;
  endfunction

  task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s dut%0d cyc=%0d pc=%0d: got %h, expected %h", nm, k, cyc, cur_pc, act, exp);
    end
  endtask

  task automatic raise_i(input int k, input logic [31:0] a);
    i_pend[k] = 1'b1;
    i_addr[k] = a;
  endtask

  task automatic raise_d(input int k, input logic we, input logic [31:0] a,
                         input logic [31:0] wd, input logic [3:0] st);
    d_pend[k]  = 1'b1;
    d_we[k]    = we;
    d_addr[k]  = a;
    d_wdata[k] = wd;
    d_wstrb[k] = st;
  endtask

  // Apply one cycle of stimulus for both DUTs, shortly after the rising edge.
  task automatic drive(input int ph, input int pc);
    int L;
    for (int k = 0; k < 2; k++) begin
      L = lat_of(k) + 1;
      rst_n[k] = 1'b1;
      case (ph)
        0: begin
          if (pc < 3) begin
            rst_n[k] = 1'b0;
            raise_i(k, rand_addr());
            raise_d(k, 1'($urandom), rand_addr(), $urandom, 4'($urandom));
          end else begin
            i_pend[k] = 1'b0;
            d_pend[k] = 1'b0;
          end
        end
        1: if (pc == 0) raise_i(k, 32'h0000_0010);
        2: begin
          if (pc == 0) raise_d(k, 1'b1, 32'h0000_0100, 32'hDEAD_BEEF, 4'hF);
          if (pc == 6) raise_d(k, 1'b0, 32'h0000_0100, $urandom, 4'($urandom));
        end
        3: if (pc == 0) begin
          raise_i(k, 32'h0000_0020);
          raise_d(k, 1'b0, 32'h0000_0104, $urandom, 4'h0);
        end
        4: begin
          if (pc < 10 * L) begin
            if (!i_pend[k]) raise_i(k, rand_addr());
            if (!d_pend[k]) raise_d(k, 1'($urandom), rand_addr(), $urandom, 4'($urandom));
          end else begin
            i_pend[k] = 1'b0;
            d_pend[k] = 1'b0;
          end
        end
        5: begin
          if (pc == 0) raise_i(k, 32'h0000_0030);
          if (pc == 1) raise_d(k, 1'b0, 32'h0000_0108, $urandom, 4'h0);
        end
        6: begin
          rst_n[k] = !((pc == 3 * L + 1) || (pc == 3 * L + 2));
          if (pc < 8 * L + 3) begin
            if (!i_pend[k]) raise_i(k, rand_addr());
            if (!d_pend[k]) raise_d(k, 1'b0, rand_addr(), $urandom, 4'($urandom));
          end else begin
            i_pend[k] = 1'b0;
            d_pend[k] = 1'b0;
          end
        end
        default: begin
          if (rst_cnt[k] == 0 && $urandom_range(0, 499) == 0) rst_cnt[k] = $urandom_range(1, 3);
          rst_n[k] = (rst_cnt[k] == 0);
          if (rst_cnt[k] > 0) rst_cnt[k]--;
          if (!i_pend[k]) begin
            if ($urandom_range(0, 2) == 0) raise_i(k, rand_addr());
          end else if ($urandom_range(0, 19) == 0) begin
            i_pend[k] = 1'b0;
          end
          if (!d_pend[k]) begin
            if ($urandom_range(0, 2) == 0)
              raise_d(k, 1'($urandom), rand_addr(), $urandom, 4'($urandom));
          end else if ($urandom_range(0, 19) == 0) begin
            d_pend[k] = 1'b0;
          end
        end
      endcase
      i_req[k]     = i_pend[k];
      d_req[k]     = d_pend[k];
      mem_rdata[k] = (cyc == env_due[k]) ? env_data[k] : $urandom;
    end
  endtask

  // Predict and compare all outputs of DUT k for the current cycle.
  task automatic model_step(input int k);
    logic        e_ig, e_dg, e_ir, e_dr, e_en, e_we, e_busy, dw, chk_mem, chk_wd;
    logic [31:0] e_ma, e_mw, e_ird, e_drd;
    logic [3:0]  e_ms;
    int          ix;
    e_ig = 1'b0; e_dg = 1'b0; e_ir = 1'b0; e_dr = 1'b0; e_en = 1'b0; e_we = 1'b0;
    e_busy = 1'b0; e_ma = 32'd0; e_mw = 32'd0; e_ird = 32'd0; e_drd = 32'd0; e_ms = 4'd0;
    chk_mem = 1'b1; chk_wd = 1'b1;
    if (rst_n[k] !== 1'b1) begin
      m_free[k]   = 0;
      m_rv_cyc[k] = -1;
      m_streak[k] = 0;
    end else if (cyc >= m_free[k]) begin
      if (i_req[k] || d_req[k]) begin
        dw   = d_req[k] && !(i_req[k] && (m_streak[k] == MAX_STREAK));
        e_en = 1'b1;
        if (dw) begin
          e_dg = 1'b1; e_we = d_we[k]; e_ma = d_addr[k]; e_mw = d_wdata[k]; e_ms = d_wstrb[k];
          ix = int'(d_addr[k][8:2]);
          if (d_we[k]) begin
            m_rv_data[k] = 32'd0;
            refmem[k][ix] = merge(refmem[k][ix], d_wdata[k], d_wstrb[k]);
          end else begin
            m_rv_data[k] = refmem[k][ix];
          end
          m_streak[k] = i_req[k] ? ((m_streak[k] + 1 > MAX_STREAK) ? MAX_STREAK : m_streak[k] + 1) : 0;
        end else begin
          e_ig = 1'b1; e_ma = i_addr[k]; chk_wd = 1'b0;
          m_rv_data[k] = refmem[k][int'(i_addr[k][8:2])];
          m_streak[k]  = 0;
        end
        m_rv_d[k]   = dw;
        m_rv_cyc[k] = cyc + lat_of(k);
        m_free[k]   = cyc + lat_of(k) + 1;
      end
    end else begin
      e_busy = 1'b1; chk_mem = 1'b0;
      if (cyc == m_rv_cyc[k]) begin
        if (m_rv_d[k]) begin e_dr = 1'b1; e_drd = m_rv_data[k]; end
        else begin e_ir = 1'b1; e_ird = m_rv_data[k]; end
      end
    end
    chk("i_gnt", k, 32'(i_gnt[k]), 32'(e_ig));
    chk("d_gnt", k, 32'(d_gnt[k]), 32'(e_dg));
    chk("i_rvalid", k, 32'(i_rvalid[k]), 32'(e_ir));
    chk("d_rvalid", k, 32'(d_rvalid[k]), 32'(e_dr));
    chk("i_rdata", k, i_rdata[k], e_ird);
    chk("d_rdata", k, d_rdata[k], e_drd);
    chk("mem_en", k, 32'(mem_en[k]), 32'(e_en));
    chk("busy", k, 32'(busy[k]), 32'(e_busy));
    if (chk_mem) begin
      chk("mem_we", k, 32'(mem_we[k]), 32'(e_we));
      chk("mem_addr", k, mem_addr[k], e_ma);
      chk("mem_wstrb", k, 32'(mem_wstrb[k]), 32'(e_ms));
      if (chk_wd) chk("mem_wdata", k, mem_wdata[k], e_mw);
    end
  endtask

  // Record actual DUT activity, retire held requests and run the memory stand-in.
  task automatic bookkeep(input int k, input int pc);
    int ix;
    if ((i_gnt[k] === 1'b1 || d_gnt[k] === 1'b1) && g_n[k] < 64) begin
      g_pc[k][g_n[k]] = pc;
      g_d[k][g_n[k]]  = d_gnt[k];
      g_we[k][g_n[k]] = mem_we[k];
      g_st[k][g_n[k]] = mem_wstrb[k];
      g_n[k]++;
    end
    if ((i_rvalid[k] === 1'b1 || d_rvalid[k] === 1'b1) && rv_n[k] < 64) begin
      rv_pc[k][rv_n[k]]   = pc;
      rv_d[k][rv_n[k]]    = d_rvalid[k];
      rv_data[k][rv_n[k]] = (d_rvalid[k] === 1'b1) ? d_rdata[k] : i_rdata[k];
      rv_n[k]++;
    end
    if (i_gnt[k] === 1'b1) i_pend[k] = 1'b0;
    if (d_gnt[k] === 1'b1) d_pend[k] = 1'b0;
    if (mem_en[k] === 1'b1) begin
      ix = int'(mem_addr[k][8:2]);
      if (mem_we[k] === 1'b1) begin
        envmem[k][ix] = merge(envmem[k][ix], mem_wdata[k], mem_wstrb[k]);
      end else begin
        env_due[k]  = cyc + lat_of(k);
        env_data[k] = envmem[k][ix];
      end
    end
  endtask

  // Hand-computed expectations for the directed phases.
  task automatic phase_check(input int ph);
    int         lt, L;
    logic [9:0] ord10;
    logic [8:0] ord9;
    for (int k = 0; k < 2; k++) begin
      lt = lat_of(k);
      L  = lt + 1;
      case (ph)
        1: begin
          chk("fetch_ngnt", k, 32'(g_n[k]), 32'd1);
          chk("fetch_gnt_pc", k, 32'(g_pc[k][0]), 32'd0);
          chk("fetch_gnt_is_i", k, 32'(g_d[k][0]), 32'd0);
          chk("fetch_rv_pc", k, 32'(rv_pc[k][0]), 32'(lt));
          chk("fetch_rdata", k, rv_data[k][0], 32'h0050_0093);
        end
        2: begin
          chk("st_ld_ngnt", k, 32'(g_n[k]), 32'd2);
          chk("store_mem_we", k, 32'(g_we[k][0]), 32'd1);
          chk("store_mem_wstrb", k, 32'(g_st[k][0]), 32'hF);
          chk("store_rv_pc", k, 32'(rv_pc[k][0]), 32'(lt));
          chk("store_rv_is_d", k, 32'(rv_d[k][0]), 32'd1);
          chk("store_rdata", k, rv_data[k][0], 32'd0);
          chk("load_rv_pc", k, 32'(rv_pc[k][1]), 32'(6 + lt));
          chk("load_rdata", k, rv_data[k][1], 32'hDEAD_BEEF);
        end
        3: begin
          chk("cont_first_is_d", k, 32'(g_d[k][0]), 32'd1);
          chk("cont_first_pc", k, 32'(g_pc[k][0]), 32'd0);
          chk("cont_second_is_i", k, 32'(g_d[k][1]), 32'd0);
          chk("cont_i_gnt_pc", k, 32'(g_pc[k][1]), 32'(L));
          chk("cont_i_rv_is_i", k, 32'(rv_d[k][1]), 32'd0);
          chk("cont_i_rv_pc", k, 32'(rv_pc[k][1]), 32'(2 * lt + 1));
        end
        4: begin
          for (int i = 0; i < 10; i++) ord10[9-i] = g_d[k][i];
          chk("starve_ngnt", k, 32'(g_n[k]), 32'd10);
          chk("starve_order", k, 32'(ord10), 32'(10'b1111011110));
          chk("starve_last_pc", k, 32'(g_pc[k][9]), 32'(9 * L));
        end
        5: begin
          chk("holdoff_i_pc", k, 32'(g_pc[k][0]), 32'd0);
          chk("holdoff_i_rv_pc", k, 32'(rv_pc[k][0]), 32'(lt));
          chk("holdoff_d_is_d", k, 32'(g_d[k][1]), 32'd1);
          chk("holdoff_d_pc", k, 32'(g_pc[k][1]), 32'(L));
        end
        6: begin
          for (int i = 0; i < 9; i++) ord9[8-i] = g_d[k][i];
          chk("rst_ngnt", k, 32'(g_n[k]), 32'd9);
          chk("rst_order", k, 32'(ord9), 32'(9'b111111110));
          chk("rst_regrant_pc", k, 32'(g_pc[k][4]), 32'(3 * L + 3));
          chk("rst_nrv", k, 32'(rv_n[k]), 32'd8);
          chk("rst_rv3_pc", k, 32'(rv_pc[k][2]), 32'(2 * L + lt));
          chk("rst_rv4_pc", k, 32'(rv_pc[k][3]), 32'(3 * L + 3 + lt));
        end
        default: ;
      endcase
    end
  endtask

  initial begin
    int plen [8];
    plen = '{6, 10, 14, 14, 44, 14, 44, 3000};
    for (int k = 0; k < 2; k++) begin
      rst_n[k] = 1'b0; i_req[k] = 1'b0; d_req[k] = 1'b0; i_pend[k] = 1'b0; d_pend[k] = 1'b0;
      i_addr[k] = 32'd0; d_we[k] = 1'b0; d_addr[k] = 32'd0; d_wdata[k] = 32'd0;
      d_wstrb[k] = 4'd0; mem_rdata[k] = 32'd0; rst_cnt[k] = 0;
      m_free[k] = 0; m_rv_cyc[k] = -1; m_streak[k] = 0; m_rv_d[k] = 1'b0;
      m_rv_data[k] = 32'd0; env_due[k] = -1; env_data[k] = 32'd0;
      for (int i = 0; i < 128; i++) begin
        refmem[k][i] = 32'h1357_0000 ^ (32'(i) * 32'h0001_0203);
        envmem[k][i] = refmem[k][i];
      end
      refmem[k][4] = 32'h0050_0093;
      envmem[k][4] = 32'h0050_0093;
    end
    for (int ph = 0; ph < 8; ph++) begin
      for (int k = 0; k < 2; k++) begin
        g_n[k] = 0; rv_n[k] = 0;
        for (int i = 0; i < 64; i++) begin
          g_pc[k][i] = -1; g_d[k][i] = 1'b0; g_we[k][i] = 1'b0; g_st[k][i] = 4'd0;
          rv_pc[k][i] = -1; rv_d[k][i] = 1'b0; rv_data[k][i] = 32'd0;
        end
      end
      for (int pc = 0; pc < plen[ph]; pc++) begin
        @(posedge clk);
        #1;
        cur_pc = pc;
        drive(ph, pc);
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
          model_step(k);
          bookkeep(k, pc);
        end
        cyc++;
      end
      phase_check(ph);
    end
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares one single-port unified memory between instruction fetch (I port, read-only) and the load/store stage (D port, read/write).
- Allows the core to run from a single RAM instead of split instruction and data memories.
- Sits between top_fetch / top_memory and the memory macro.
- Serializes accesses with a small FSM, fixed-latency response tracking and a starvation guard so fetch always makes progress.

Parameters:
- ADDR_WIDTH, 32, byte address width.
- DATA_WIDTH, 32, data word width.
- MEM_LAT, 1, memory read latency in cycles (>=1); mem_rdata is valid MEM_LAT cycles after the mem_en cycle.
- MAX_STREAK, 4, consecutive contested D grants allowed before I is forced to win.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- i_req  in  1  fetch request; held with i_addr until i_gnt
- i_addr  in  ADDR_WIDTH  fetch address
- i_gnt  out  1  fetch request accepted this cycle
- i_rvalid  out  1  i_rdata valid this cycle
- i_rdata  out  DATA_WIDTH  fetch data
- d_req  in  1  data request; held with d_addr/d_we/d_wdata/d_wstrb until d_gnt
- d_we  in  1  1 = store, 0 = load
- d_addr  in  ADDR_WIDTH  data address
- d_wdata  in  DATA_WIDTH  store data
- d_wstrb  in  DATA_WIDTH/8  byte write strobes
- d_gnt  out  1  data request accepted this cycle
- d_rvalid  out  1  load data valid / store complete
- d_rdata  out  DATA_WIDTH  load data; 0 for stores
- mem_en  out  1  memory access strobe
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_WIDTH  memory address
- mem_wdata  out  DATA_WIDTH  memory write data
- mem_wstrb  out  DATA_WIDTH/8  memory byte strobes
- mem_rdata  in  DATA_WIDTH  memory read data
- busy  out  1  transaction in flight

Behaviour:
- **FSM states:** IDLE, BUSY. Owner register (I/D), latency counter lat_cnt, streak counter streak.
- **Reset (rst=0, async):** state=IDLE, lat_cnt=0, streak=0, owner=I. All outputs 0 while reset is asserted and in the first cycle after release with no request.
- **IDLE, no request:** all strobes 0; mem_* outputs are 0.
- **IDLE, request present:** arbitrate combinationally in the same cycle.
  - Assert the winner's gnt and mem_en=1.
  - Drive mem_addr/mem_we/mem_wdata/mem_wstrb from the winner. The I port always drives we=0 and wstrb=0.
  - Latch owner and request type; go to BUSY with lat_cnt=1.
- **Arbitration:**
  - Only one request: that requester wins.
  - Both requesting: D wins unless streak==MAX_STREAK, in which case I wins.
- **Streak update at each grant:**
  - D granted while i_req=1: streak+1, saturating at MAX_STREAK.
  - I granted, or D granted with i_req=0: streak=0.
- **BUSY:**
  - gnt outputs 0; mem_en=0; requests are ignored and must be held by the requester.
  - lat_cnt increments each cycle.
  - In the cycle where lat_cnt==MAX(MEM_LAT,1): assert the owner's rvalid for exactly one cycle.
    - Owner I: i_rdata=mem_rdata.
    - Owner D, load: d_rdata=mem_rdata.
    - Owner D, store: d_rdata=0.
  - The next state is IDLE.
- **Throughput and latency:**
  - One transaction every MEM_LAT+1 cycles.
  - Grant-to-rvalid latency is MEM_LAT cycles.
  - A new grant is never issued in an rvalid cycle.
- **rdata gating:** non-owner rdata is 0; rdata is 0 whenever rvalid=0.
- **busy:** 1 in BUSY, 0 in IDLE.
- **Request withdrawn before gnt:** legal; no grant is issued for it.
- **Reset mid-BUSY:** the transaction is abandoned with no rvalid. A late mem_rdata is ignored. The FSM resumes in IDLE.
- **Address handling:** addresses pass through unmodified; alignment is the requester's responsibility.

Test Plan:
1. **Single fetch:** MEM_LAT=1, i_req=1, i_addr=0x10, mem returns 0x00500093.
   - Cycle 0: i_gnt=1, mem_en=1, mem_addr=0x10.
   - Cycle 1: i_rvalid=1, i_rdata=0x00500093, busy=1.
   - Cycle 2: busy=0.
2. **Store then load:**
   - Store d_addr=0x100, d_wdata=0xDEADBEEF, d_wstrb=0xF → mem_we=1, mem_wstrb=0xF; d_rvalid one cycle later with d_rdata=0.
   - Subsequent load of 0x100 → d_rdata=0xDEADBEEF.
3. **Contention:** i_req and d_req both rise in the same cycle → d_gnt first; i_gnt at cycle MEM_LAT+1; i_rvalid at cycle 2*MEM_LAT+1.
4. **Starvation guard:** MAX_STREAK=4, d_req and i_req held continuously → grant order D,D,D,D,I,D,D,D,D,I.
5. **Latency and hold-off:** MEM_LAT=3, fetch granted at cycle 0.
   - i_rvalid at cycle 3 exactly.
   - A d_req raised at cycle 1 gets d_gnt at cycle 4, not earlier.
6. **Reset mid-BUSY:** rst=0 in cycle 1 of a MEM_LAT=3 load → no d_rvalid; busy=0 immediately.
   - After release, a fresh d_req is granted in its first cycle, with streak=0.
